// File: rtl/fetch_redirect_unit.sv
// IF stage: PC register, PC+4, IF/ID capture, EX-stage redirect with IF/ID squash and stall hold.
// Optional redirect/stall statistics counters when BRANCH_STATS_EN is defined.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             NextPCSrc,
  input  logic [31:0]      BrTarget,
  input  logic [31:0]      InstrIn,
  output logic [31:0]      PCOut,
  output logic [31:0]      IFID_PC,
  output logic [31:0]      IFID_PC4,
  output logic [31:0]      IFID_Instr,
  output logic             IFID_Valid,
`ifdef BRANCH_STATS_EN
  output logic [CNT_W-1:0] TakenCnt,
  output logic [CNT_W-1:0] StallCnt,
`endif
  output logic             FlushIDEX
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect beats stall so a taken branch is never lost behind a hazard hold.
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (NextPCSrc) begin
      pc_d         = {BrTarget[31:2], 2'b00};
      ifid_pc_d    = 32'd0;
      ifid_pc4_d   = 32'd0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (!Stall) begin
      pc_d         = pc_plus4;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_instr_d = InstrIn;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign PCOut      = pc_q;
  assign IFID_PC    = ifid_pc_q;
  assign IFID_PC4   = ifid_pc4_q;
  assign IFID_Instr = ifid_instr_q;
  assign IFID_Valid = ifid_valid_q;
  assign FlushIDEX  = NextPCSrc & ~rst;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (NextPCSrc) begin
      if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end else if (Stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign TakenCnt = taken_cnt_q;
  assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: behavioural pipeline model checked every cycle,
// plus hand-computed literal checks. Stats checks are enabled with BRANCH_STATS_EN.
module tb_fetch_redirect_unit;

  logic        clk;
  logic        rst;
  logic        Stall;
  logic        NextPCSrc;
  logic [31:0] BrTarget;
  logic [31:0] InstrIn;
  logic [31:0] PCOut, IFID_PC, IFID_PC4, IFID_Instr;
  logic        IFID_Valid, FlushIDEX;
`ifdef BRANCH_STATS_EN
  logic [31:0] TakenCnt, StallCnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_redirect_unit dut (
    .clk(clk), .rst(rst), .Stall(Stall), .NextPCSrc(NextPCSrc),
    .BrTarget(BrTarget), .InstrIn(InstrIn), .PCOut(PCOut),
    .IFID_PC(IFID_PC), .IFID_PC4(IFID_PC4), .IFID_Instr(IFID_Instr),
    .IFID_Valid(IFID_Valid),
`ifdef BRANCH_STATS_EN
    .TakenCnt(TakenCnt), .StallCnt(StallCnt),
`endif
    .FlushIDEX(FlushIDEX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: any address-dependent pattern distinct from the PC.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  assign InstrIn = imem(PCOut);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what IF and IF/ID must hold after each edge.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_valid, m_ok;
  longint      m_taken, m_stall;
  initial m_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_ipc = 0; m_ipc4 = 0; m_instr = 32'h13; m_valid = 0;
      m_taken = 0; m_stall = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (NextPCSrc) begin
        m_pc = BrTarget & 32'hFFFF_FFFC;
        m_ipc = 0; m_ipc4 = 0; m_instr = 32'h13; m_valid = 0;
        m_taken++;
      end else if (Stall) begin
        m_stall++;
      end else begin
        m_ipc = m_pc; m_instr = imem(m_pc); m_valid = 1;
        m_pc = m_pc + 32'd4; m_ipc4 = m_pc;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model_pc", PCOut, m_pc);
      check("model_ifid_pc", IFID_PC, m_ipc);
      check("model_ifid_pc4", IFID_PC4, m_ipc4);
      check("model_ifid_instr", IFID_Instr, m_instr);
      check("model_ifid_valid", {31'd0, IFID_Valid}, {31'd0, m_valid});
      check("model_flush", {31'd0, FlushIDEX}, {31'd0, NextPCSrc & ~rst});
`ifdef BRANCH_STATS_EN
      check("model_taken_cnt", TakenCnt, m_taken[31:0]);
      check("model_stall_cnt", StallCnt, m_stall[31:0]);
`endif
    end
  end

  task automatic drive(input logic r, input logic s, input logic n, input logic [31:0] t);
    rst = r; Stall = s; NextPCSrc = n; BrTarget = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic r, input logic s, input logic n, input logic [31:0] t);
    drive(r, s, n, t);
    tick();
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    check("rst_pc", PCOut, 32'h0);
    check("rst_valid", {31'd0, IFID_Valid}, 32'd0);
    check("rst_instr", IFID_Instr, 32'h0000_0013);
    check("rst_flush", {31'd0, FlushIDEX}, 32'd0);

    // Redirect asserted during reset must not flush.
    drive(1'b1, 1'b0, 1'b1, 32'h200);
    #1 check("rst_flush_masked", {31'd0, FlushIDEX}, 32'd0);
    tick();
    check("rst_over_redirect", PCOut, 32'h0);

    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("seq1_pc", PCOut, 32'h4);
    check("seq1_ifid_pc", IFID_PC, 32'h0);
    check("seq1_instr", IFID_Instr, imem(32'h0));
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("seq2_pc", PCOut, 32'h8);
    check("seq2_ifid_pc", IFID_PC, 32'h4);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("seq3_pc", PCOut, 32'hC);
    check("seq3_ifid_pc", IFID_PC, 32'h8);
    check("seq3_ifid_pc4", IFID_PC4, 32'hC);
    check("seq3_valid", {31'd0, IFID_Valid}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("seq4_pc", PCOut, 32'h10);

    drive(1'b0, 1'b0, 1'b1, 32'h100);
    #1 check("redir_flush", {31'd0, FlushIDEX}, 32'd1);
    tick();
    check("redir_pc", PCOut, 32'h100);
    check("redir_valid", {31'd0, IFID_Valid}, 32'd0);
    check("redir_instr", IFID_Instr, 32'h13);

    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("post_redir_pc", PCOut, 32'h108);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("stall_pc", PCOut, 32'h108);
    check("stall_ifid_pc", IFID_PC, 32'h104);
    check("stall_valid", {31'd0, IFID_Valid}, 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 32'h41);
    check("stall_redir_pc", PCOut, 32'h40);
    check("stall_redir_valid", {31'd0, IFID_Valid}, 32'd0);

    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    check("wrap_pre_pc", PCOut, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_pc", PCOut, 32'h0);
    check("wrap_ifid_pc", IFID_PC, 32'hFFFF_FFFC);
    check("wrap_ifid_pc4", IFID_PC4, 32'h0);

    // Stats window: 3 redirects and 5 stall-only cycles from a clean reset.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h80);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h203);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h300);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("stats_pc", PCOut, 32'h300);
`ifdef BRANCH_STATS_EN
    check("stats_taken", TakenCnt, 32'd3);
    check("stats_stall", StallCnt, 32'd5);
`endif
    // Reset in the middle of a stall restarts cleanly.
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("rst_mid_stall_pc", PCOut, 32'h0);
    check("rst_mid_stall_valid", {31'd0, IFID_Valid}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("rst_taken", TakenCnt, 32'd0);
    check("rst_stall", StallCnt, 32'd0);
`endif

    // Mixed tail exercised only by the per-cycle model.
    for (int i = 0; i < 200; i++) begin
      int unsigned k;
      k = $urandom_range(0, 9);
      cyc(k == 0, k inside {[1:3]}, k inside {[3:4]}, $urandom);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
